// File: rtl/mips_pkg.sv
// Shared definitions for the multicycle MIPS core: opcodes, functs, FSM states,
// ALU control codes, error codes and small decode/ALU helpers.
package mips_pkg;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_SLT = 6'h2A;

    typedef enum logic [2:0] {
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_BRANCH,
        S_MEM,
        S_WB,
        S_HALT
    } state_e;

    typedef enum logic [2:0] {
        ALU_ADD,
        ALU_SUB,
        ALU_AND,
        ALU_OR,
        ALU_SLT
    } alu_ctrl_e;

    typedef enum logic [1:0] {
        ERR_NONE    = 2'd0,
        ERR_ILLEGAL = 2'd1,
        ERR_ALIGN   = 2'd2,
        ERR_TIMEOUT = 2'd3
    } err_e;

    function automatic logic is_legal(input logic [5:0] op, input logic [5:0] fn);
        case (op)
            OP_RTYPE: return fn inside {FN_ADD, FN_SUB, FN_AND, FN_OR, FN_SLT};
            OP_ADDI, OP_LW, OP_SW, OP_BEQ, OP_BNE, OP_J: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    // Non-R-type instructions that reach EXEC (addi/lw/sw) all add.
    function automatic alu_ctrl_e alu_ctrl(input logic [5:0] op, input logic [5:0] fn);
        if (op != OP_RTYPE) return ALU_ADD;
        case (fn)
            FN_SUB:  return ALU_SUB;
            FN_AND:  return ALU_AND;
            FN_OR:   return ALU_OR;
            FN_SLT:  return ALU_SLT;
            default: return ALU_ADD;
        endcase
    endfunction

    function automatic logic [31:0] alu(input alu_ctrl_e ctrl, input logic [31:0] a,
                                        input logic [31:0] b);
        case (ctrl)
            ALU_SUB: return a - b;
            ALU_AND: return a & b;
            ALU_OR:  return a | b;
            ALU_SLT: return {31'd0, $signed(a) < $signed(b)};
            default: return a + b;
        endcase
    endfunction

endpackage

// File: rtl/mips_regfile.sv
// 32x32 register file: two asynchronous read ports, one synchronous write port,
// register 0 hardwired to zero. Contents are deliberately not reset.
module mips_regfile (
    input  logic        clk,
    input  logic        we,
    input  logic [4:0]  waddr,
    input  logic [31:0] wdata,
    input  logic [4:0]  raddr_a,
    output logic [31:0] rdata_a,
    input  logic [4:0]  raddr_b,
    output logic [31:0] rdata_b
);

    logic [31:0] regs [32];

    always_ff @(posedge clk) begin
        if (we && (waddr != 5'd0)) begin
            regs[waddr] <= wdata;
        end
    end

    assign rdata_a = (raddr_a == 5'd0) ? '0 : regs[raddr_a];
    assign rdata_b = (raddr_b == 5'd0) ? '0 : regs[raddr_b];

endmodule

// File: rtl/mips_multicycle_core.sv
// Multicycle MIPS subset core (FETCH/DECODE/EXEC/BRANCH/MEM/WB/HALT) with a
// req/ack memory port, optional ack timeout and sticky error reporting.
module mips_multicycle_core
    import mips_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int unsigned WAIT_LIMIT = 0
) (
    input  logic        clk,
    input  logic        reset,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    output logic [31:0] pc_current,
    output logic [31:0] result,
    output logic        retire,
    output logic        halted,
    output logic [1:0]  err_code
);

    state_e      state, state_nx;
    logic [31:0] pc, ir, a_reg, b_reg, alu_out, mdr, result_r;
    logic [31:0] wait_cnt;
    err_e        err_r;

    logic [5:0]  op, fn;
    logic [4:0]  rs, rt, rd;
    logic [31:0] sext, alu_res, wb_data, rdata_a, rdata_b;
    logic        legal, is_mem_op, timeout_hit, req_state, rf_we;
    logic        unused_shamt;

    assign op   = ir[31:26];
    assign rs   = ir[25:21];
    assign rt   = ir[20:16];
    assign rd   = ir[15:11];
    assign fn   = ir[5:0];
    assign sext = {{16{ir[15]}}, ir[15:0]};
    assign unused_shamt = ^ir[10:6];

    assign legal     = is_legal(op, fn);
    assign is_mem_op = (op == OP_LW) || (op == OP_SW);
    assign alu_res   = alu(alu_ctrl(op, fn), a_reg, (op == OP_RTYPE) ? b_reg : sext);
    assign wb_data   = (op == OP_LW) ? mdr : alu_out;
    assign req_state = (state == S_FETCH) || (state == S_MEM);
    assign timeout_hit = (WAIT_LIMIT != 0) && ((wait_cnt + 32'd1) >= WAIT_LIMIT);

    mips_regfile u_regfile (
        .clk     (clk),
        .we      (rf_we),
        .waddr   ((op == OP_RTYPE) ? rd : rt),
        .wdata   (wb_data),
        .raddr_a (rs),
        .rdata_a (rdata_a),
        .raddr_b (rt),
        .rdata_b (rdata_b)
    );

    always_comb begin
        state_nx  = state;
        retire    = 1'b0;
        rf_we     = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = pc;
        case (state)
            S_FETCH: begin
                if (mem_ack)          state_nx = S_DECODE;
                else if (timeout_hit) state_nx = S_HALT;
            end
            S_DECODE: begin
                if (!legal) begin
                    state_nx = S_HALT;
                end else if (op == OP_J) begin
                    retire   = 1'b1;
                    state_nx = S_FETCH;
                end else if ((op == OP_BEQ) || (op == OP_BNE)) begin
                    state_nx = S_BRANCH;
                end else begin
                    state_nx = S_EXEC;
                end
            end
            S_EXEC: begin
                if (!is_mem_op)                state_nx = S_WB;
                else if (alu_res[1:0] != 2'b0) state_nx = S_HALT;
                else                           state_nx = S_MEM;
            end
            S_BRANCH: begin
                retire   = 1'b1;
                state_nx = S_FETCH;
            end
            S_MEM: begin
                mem_addr = alu_out;
                mem_we   = (op == OP_SW);
                if (mem_ack) begin
                    retire   = (op == OP_SW);
                    state_nx = (op == OP_SW) ? S_FETCH : S_WB;
                end else if (timeout_hit) begin
                    state_nx = S_HALT;
                end
            end
            S_WB: begin
                rf_we    = 1'b1;
                retire   = 1'b1;
                state_nx = S_FETCH;
            end
            default: state_nx = S_HALT;
        endcase
    end

    // Gating with the reset level keeps mem_req low while reset is held even
    // though the state register already sits in FETCH.
    assign mem_req    = req_state && reset;
    assign mem_wdata  = b_reg;
    assign pc_current = pc;
    assign result     = result_r;
    assign halted     = (state == S_HALT);
    assign err_code   = err_r;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= S_FETCH;
            pc       <= RESET_PC;
            ir       <= '0;
            a_reg    <= '0;
            b_reg    <= '0;
            alu_out  <= '0;
            mdr      <= '0;
            result_r <= '0;
            err_r    <= ERR_NONE;
            wait_cnt <= '0;
        end else begin
            state <= state_nx;
            if (req_state && !mem_ack) wait_cnt <= wait_cnt + 32'd1;
            else                       wait_cnt <= '0;
            case (state)
                S_FETCH: begin
                    if (mem_ack) begin
                        ir <= mem_rdata;
                        pc <= pc + 32'd4;
                    end else if (timeout_hit) begin
                        err_r <= ERR_TIMEOUT;
                    end
                end
                S_DECODE: begin
                    a_reg   <= rdata_a;
                    b_reg   <= rdata_b;
                    alu_out <= pc + {sext[29:0], 2'b00};
                    if (!legal)          err_r <= ERR_ILLEGAL;
                    else if (op == OP_J) pc    <= {pc[31:28], ir[25:0], 2'b00};
                end
                S_EXEC: begin
                    alu_out <= alu_res;
                    if (is_mem_op && (alu_res[1:0] != 2'b0)) err_r <= ERR_ALIGN;
                end
                S_BRANCH: begin
                    if ((op == OP_BEQ) == (a_reg == b_reg)) pc <= alu_out;
                end
                S_MEM: begin
                    if (mem_ack) begin
                        if (op == OP_LW) mdr <= mem_rdata;
                    end else if (timeout_hit) begin
                        err_r <= ERR_TIMEOUT;
                    end
                end
                S_WB: result_r <= wb_data;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mips_multicycle_core.sv
// Scoreboard bench: an ISA-level model predicts each retirement (next pc, result,
// cycle cost) and each store; a memory responder/monitor checks the DUT against it.
module tb_mips_multicycle_core;

    localparam logic [31:0] RST_PC = 32'hFFFF_FFFC;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        mem_req, mem_we, mem_ack, retire, halted;
    logic [31:0] mem_addr, mem_wdata, mem_rdata, pc_current, result;
    logic [1:0]  err_code;

    mips_multicycle_core #(.RESET_PC(RST_PC), .WAIT_LIMIT(4)) dut (
        .clk        (clk),
        .reset      (reset),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_ack    (mem_ack),
        .mem_rdata  (mem_rdata),
        .pc_current (pc_current),
        .result     (result),
        .retire     (retire),
        .halted     (halted),
        .err_code   (err_code)
    );

    always #5 clk = ~clk;

    typedef struct { bit [31:0] pc_next; bit [31:0] res; int cycles; } ret_t;
    typedef struct { bit [31:0] addr; bit [31:0] data; } st_t;

    bit [31:0] mem  [bit [31:0]];
    bit [31:0] mmem [bit [31:0]];
    ret_t      exp_q [$];
    st_t       st_q  [$];
    bit [1:0]  exp_err;

    int compared = 0, mismatched = 0;
    int cyc = 0, last_ret = 0, wait_acc = 0, req_cycles = 0;
    int max_delay = 3;
    bit never_ack = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic bit [31:0] rtype(input bit [5:0] fn, input bit [4:0] rs, input bit [4:0] rt,
                                        input bit [4:0] rd);
        return {6'h00, rs, rt, rd, 5'd0, fn};
    endfunction

    function automatic bit [31:0] itype(input bit [5:0] op, input bit [4:0] rs, input bit [4:0] rt,
                                        input bit [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    function automatic bit [31:0] jtype(input bit [31:0] target);
        return {6'h02, target[27:2]};
    endfunction

    task automatic load(input bit [31:0] a, input bit [31:0] w);
        mem[a]  = w;
        mmem[a] = w;
    endtask

    // ISA-level reference: executes the program image instruction by instruction.
    task automatic run_model(input bit [31:0] start_pc);
        bit [31:0] r [32];
        bit [31:0] pc, ins, res, addr, v, sx;
        bit [5:0]  op, fn;
        bit [4:0]  rs, rt, rd;
        bit        done, taken;
        ret_t      e;
        st_t       s;
        for (int i = 0; i < 32; i++) r[i] = 32'd0;
        pc = start_pc; res = 32'd0; done = 1'b0; exp_err = 2'd0;
        for (int n = 0; n < 2000 && !done; n++) begin
            ins = mmem.exists(pc) ? mmem[pc] : 32'd0;
            op = ins[31:26]; rs = ins[25:21]; rt = ins[20:16]; rd = ins[15:11]; fn = ins[5:0];
            sx = {{16{ins[15]}}, ins[15:0]};
            e.cycles = 0;
            case (op)
                6'h00: begin
                    e.cycles = 4;
                    case (fn)
                        6'h20: v = r[rs] + r[rt];
                        6'h22: v = r[rs] - r[rt];
                        6'h24: v = r[rs] & r[rt];
                        6'h25: v = r[rs] | r[rt];
                        6'h2A: v = ($signed(r[rs]) < $signed(r[rt])) ? 32'd1 : 32'd0;
                        default: begin done = 1'b1; exp_err = 2'd1; end
                    endcase
                    if (!done) begin
                        if (rd != 0) r[rd] = v;
                        res = v; pc = pc + 4;
                    end
                end
                6'h08: begin
                    e.cycles = 4; v = r[rs] + sx;
                    if (rt != 0) r[rt] = v;
                    res = v; pc = pc + 4;
                end
                6'h23, 6'h2B: begin
                    addr = r[rs] + sx;
                    if (addr[1:0] != 2'b00) begin
                        done = 1'b1; exp_err = 2'd2;
                    end else if (op == 6'h23) begin
                        e.cycles = 5;
                        v = mmem.exists(addr) ? mmem[addr] : 32'd0;
                        if (rt != 0) r[rt] = v;
                        res = v; pc = pc + 4;
                    end else begin
                        e.cycles = 4;
                        mmem[addr] = r[rt];
                        s.addr = addr; s.data = r[rt]; st_q.push_back(s);
                        pc = pc + 4;
                    end
                end
                6'h04, 6'h05: begin
                    e.cycles = 3;
                    taken = (op == 6'h04) ? (r[rs] == r[rt]) : (r[rs] != r[rt]);
                    pc = pc + 4;
                    if (taken) pc = pc + (sx << 2);
                end
                6'h02: begin
                    e.cycles = 2;
                    v  = pc + 4;
                    pc = {v[31:28], ins[25:0], 2'b00};
                end
                default: begin done = 1'b1; exp_err = 2'd1; end
            endcase
            if (!done) begin
                e.pc_next = pc; e.res = res;
                exp_q.push_back(e);
            end
        end
    endtask

    // Memory responder and retirement monitor share one process so the wait
    // accounting and retire sampling happen in a fixed order each cycle.
    initial begin : responder
        bit   busy, pending, was_low;
        int   d, cnt;
        ret_t cur;
        st_t  s;
        busy = 0; pending = 0; was_low = 1; d = 0; cnt = 0;
        mem_ack = 1'b0; mem_rdata = 32'd0;
        forever begin
            @(negedge clk);
            cyc++;
            if (!reset) begin
                busy = 0; pending = 0; was_low = 1; mem_ack = 1'b0;
                wait_acc = 0; req_cycles = 0;
            end else begin
                if (was_low) begin was_low = 0; last_ret = cyc - 1; end
                if (pending) begin
                    check("pc_after_retire", pc_current, cur.pc_next);
                    check("result_after_retire", result, cur.res);
                    pending = 0;
                end
                mem_ack = 1'b0;
                if (mem_req) begin
                    req_cycles++;
                    if (!busy && !never_ack) begin
                        busy = 1; cnt = 0;
                        d = $urandom_range(0, max_delay);
                        wait_acc += d;
                    end
                    if (busy) begin
                        if (cnt == d) begin
                            mem_ack = 1'b1; busy = 0;
                            if (mem_we) begin
                                if (st_q.size() == 0) begin
                                    compared++; mismatched++;
                                    $display("FAIL unexpected_store: addr %h data %h", mem_addr, mem_wdata);
                                end else begin
                                    s = st_q.pop_front();
                                    check("store_addr", mem_addr, s.addr);
                                    check("store_data", mem_wdata, s.data);
                                end
                                mem[mem_addr] = mem_wdata;
                            end else begin
                                mem_rdata = mem.exists(mem_addr) ? mem[mem_addr] : 32'd0;
                            end
                        end else begin
                            cnt++;
                        end
                    end
                end
                #1;
                if (retire) begin
                    if (exp_q.size() == 0) begin
                        compared++; mismatched++;
                        $display("FAIL unexpected_retire: pc %h, expected none", pc_current);
                    end else begin
                        cur = exp_q.pop_front();
                        check("retire_cycles", cyc - last_ret, cur.cycles + wait_acc);
                        pending = 1;
                    end
                    wait_acc = 0;
                    last_ret = cyc;
                end
            end
        end
    end

    task automatic reset_assert();
        @(posedge clk);
        #2 reset = 1'b0;
        #1;
        check("rst_mem_req", mem_req, 1'b0);
        check("rst_retire", retire, 1'b0);
        check("rst_halted", halted, 1'b0);
        check("rst_err", err_code, 2'd0);
        check("rst_result", result, 32'd0);
        check("rst_pc", pc_current, RST_PC);
        mem.delete(); mmem.delete(); exp_q.delete(); st_q.delete();
    endtask

    task automatic reset_release();
        repeat (2) @(posedge clk);
        #2 reset = 1'b1;
    endtask

    task automatic run_to_halt();
        int n, snap;
        n = 0;
        while (!halted && n < 4000) begin
            @(negedge clk); #2; n++;
        end
        check("halt_reached", halted, 1'b1);
        check("halt_err_code", err_code, exp_err);
        repeat (3) @(negedge clk);
        #2;
        check("retires_left", exp_q.size(), 0);
        check("stores_left", st_q.size(), 0);
        snap = req_cycles;
        repeat (5) @(negedge clk);
        #2;
        check("halt_no_req", req_cycles - snap, 0);
    endtask

    task automatic gen_random(input int n);
        bit [31:0] a, t;
        bit [15:0] off;
        bit [5:0]  fns [5];
        fns[0] = 6'h20; fns[1] = 6'h22; fns[2] = 6'h24; fns[3] = 6'h25; fns[4] = 6'h2A;
        a = RST_PC;
        load(a, itype(6'h08, 5'd0, 5'd7, 16'h0400)); a += 4;
        for (int k = 1; k < 7; k++) begin
            load(a, itype(6'h08, 5'd0, 5'(k), 16'($urandom))); a += 4;
        end
        for (int i = 0; i < n; i++) begin
            off = {8'd0, 6'($urandom_range(0, 63)), 2'b00};
            case ($urandom_range(0, 8))
                0, 1, 8: load(a, rtype(fns[$urandom_range(0, 4)], 5'($urandom_range(0, 7)),
                                       5'($urandom_range(0, 7)), 5'($urandom_range(0, 6))));
                2: load(a, itype(6'h08, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 6)),
                                 16'($urandom)));
                3: load(a, itype(6'h23, 5'd7, 5'($urandom_range(0, 6)), off));
                4: load(a, itype(6'h2B, 5'd7, 5'($urandom_range(0, 7)), off));
                5: load(a, itype(6'h04, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                                 16'($urandom_range(0, 3))));
                6: load(a, itype(6'h05, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                                 16'($urandom_range(0, 3))));
                default: begin
                    t = a + 4 + 4 * $urandom_range(0, 3);
                    load(a, jtype(t));
                end
            endcase
            a += 4;
        end
        for (int k = 0; k < 4; k++) begin
            load(a, 32'hFC00_0000); a += 4;
        end
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation exceeded its time budget");
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        int n;
        // Directed program: nop at the wrapping reset PC, then arithmetic, store/load, branches, jump.
        reset_assert();
        load(RST_PC,        rtype(6'h20, 5'd0, 5'd0, 5'd0));
        load(32'h0000_0000, itype(6'h08, 5'd0, 5'd1, 16'd5));
        load(32'h0000_0004, rtype(6'h20, 5'd1, 5'd1, 5'd2));
        load(32'h0000_0008, itype(6'h2B, 5'd0, 5'd2, 16'd8));
        load(32'h0000_000C, itype(6'h23, 5'd0, 5'd3, 16'd8));
        load(32'h0000_0010, itype(6'h05, 5'd1, 5'd1, 16'd5));
        load(32'h0000_0014, itype(6'h04, 5'd1, 5'd1, 16'd1));
        load(32'h0000_0018, 32'hFC00_0000);
        load(32'h0000_001C, jtype(32'h0000_0040));
        load(32'h0000_0040, itype(6'h04, 5'd1, 5'd2, 16'hFFFF));
        load(32'h0000_0044, rtype(6'h20, 5'd3, 5'd1, 5'd4));
        load(32'h0000_0048, rtype(6'h2A, 5'd4, 5'd1, 5'd5));
        load(32'h0000_004C, rtype(6'h22, 5'd1, 5'd4, 5'd6));
        load(32'h0000_0050, rtype(6'h2A, 5'd6, 5'd1, 5'd0));
        load(32'h0000_0054, rtype(6'h25, 5'd6, 5'd3, 5'd0));
        load(32'h0000_0058, 32'hFC00_0000);
        run_model(RST_PC);
        reset_release();
        run_to_halt();

        // Misaligned load.
        reset_assert();
        load(RST_PC, itype(6'h23, 5'd0, 5'd1, 16'd6));
        run_model(RST_PC);
        reset_release();
        run_to_halt();

        // Randomized programs with random ack latency.
        for (int p = 0; p < 4; p++) begin
            reset_assert();
            gen_random(60);
            run_model(RST_PC);
            reset_release();
            run_to_halt();
        end

        // Timeout: no ack ever arrives.
        reset_assert();
        never_ack = 1'b1;
        reset_release();
        n = 0;
        while (!halted && n < 50) begin
            @(negedge clk); #2; n++;
        end
        check("timeout_halted", halted, 1'b1);
        check("timeout_err", err_code, 2'd3);
        check("timeout_req_cycles", req_cycles, 4);

        // Reset in the middle of a pending fetch.
        reset_assert();
        reset_release();
        repeat (2) @(negedge clk);
        #2;
        check("req_before_reset", mem_req, 1'b1);
        reset_assert();
        never_ack = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/mips_multicycle_core.md
MIPS_MULTICYCLE_CORE -- requirements
Module: mips_multicycle_core

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000: PC value loaded on reset.
REQ-002 Parameter WAIT_LIMIT, default 0: maximum mem_ack wait cycles per transaction; 0 disables the timeout.
REQ-003 clk  in  1  single clock; all state updates on the rising edge.
REQ-004 reset  in  1  asynchronous, active-low reset.
REQ-005 mem_req  out  1  memory transaction request.
REQ-006 mem_we  out  1  1 = write, 0 = read; valid while mem_req=1.
REQ-007 mem_addr  out  32  byte address, word-aligned.
REQ-008 mem_wdata  out  32  store data.
REQ-009 mem_ack  in  1  transaction complete; mem_rdata valid in the same cycle.
REQ-010 mem_rdata  in  32  read data.
REQ-011 pc_current  out  32  architectural PC.
REQ-012 result  out  32  last value written back to the register file.
REQ-013 retire  out  1  one-cycle pulse per completed instruction.
REQ-014 halted  out  1  core stopped in HALT.
REQ-015 err_code  out  2  0 none, 1 illegal opcode/funct, 2 misaligned load/store, 3 memory timeout.

Function
REQ-016 Supported instructions: R-type add/sub/and/or/slt (funct 20/22/24/25/2A hex), addi 08, lw 23, sw 2B, beq 04, bne 05, j 02; anything else is illegal.
REQ-017 FSM states: FETCH, DECODE, EXEC, BRANCH, MEM, WB, HALT.
REQ-018 FETCH: mem_req=1, mem_we=0, mem_addr=pc; on ack, latch IR and set pc<=pc+4 (mod 2^32), then go to DECODE.
REQ-019 DECODE: latch rs/rt into A/B and precompute pc+4+(sext(imm)<<2); j sets pc<={pc[31:28],imm26,2'b00}, pulses retire, goes to FETCH; beq/bne goes to BRANCH; illegal goes to HALT with err 1; all others go to EXEC.
REQ-020 BRANCH: take the branch if (A==B) for beq or (A!=B) for bne, pulse retire, go to FETCH.
REQ-021 EXEC: ALUOut = A op B (R-type) or A+sext(imm); R/addi go to WB; lw/sw go to MEM, or to HALT with err 2 if ALUOut[1:0]!=0.
REQ-022 MEM: mem_req=1, mem_addr=ALUOut, mem_we=(sw), mem_wdata=B; on ack, sw pulses retire and goes to FETCH; lw latches MDR and goes to WB.
REQ-023 WB: write rd (R-type) or rt (addi/lw) with ALU or MDR data, update result, pulse retire, go to FETCH.
REQ-024 Writes to $0 are discarded; $0 always reads 0; result updates even for $0 writes.
REQ-025 Cycle counts with zero-wait memory (ack in the first req cycle): j 2, beq/bne 3, R/addi 4, sw 4, lw 5; each wait cycle adds 1.
REQ-026 Handshake: mem_req, mem_we, mem_addr and mem_wdata hold stable until the ack edge; mem_req drops in the cycle after ack; mem_ack while mem_req=0 is ignored.
REQ-027 Timeout: a wait counter clears on request start; when WAIT_LIMIT!=0 and the counter reaches WAIT_LIMIT without ack, go to HALT with err 3 and drop mem_req.
REQ-028 HALT is terminal until reset: mem_req=0, retire=0, halted=1, err_code held.
REQ-029 add/sub/addi wrap modulo 2^32 with no overflow trap; slt is a signed compare.

Reset
REQ-030 Asserting reset at any time, including mid-transaction, immediately forces state=FETCH, pc=RESET_PC, mem_req=0, retire=0, halted=0, err_code=0, result=0, IR/A/B/ALUOut/MDR=0.
REQ-031 Register file contents are not reset; only $0 is guaranteed to read 0.
REQ-032 The first mem_req is issued in the first cycle after reset deasserts.

Structure
REQ-033 Package mips_pkg holds: opcode and funct constants, the state enum, ALU control codes, and err_code values.
REQ-034 Sub-module mips_regfile: 32x32, two asynchronous read ports, one synchronous write port, $0 hardwired to zero.

Verification
REQ-035 Zero-wait memory, addi $1,$0,5 then add $2,$1,$1 -> result=10, retire pulses 4 cycles apart.
REQ-036 sw $2,8($0) then lw $3,8($0) with ack delayed 3 cycles -> write to address 8 with wdata=10, $3=10, lw takes 8 cycles.
REQ-037 beq $1,$1,-1 at pc 0x40 -> pc returns to 0x40; bne on equal registers -> pc=0x44.
REQ-038 Opcode 3F -> halted=1, err_code=1, no further mem_req; lw at address 0x6 -> err_code=2.
REQ-039 WAIT_LIMIT=4 with ack never asserted -> halted with err_code=3 after 4 wait cycles; reset asserted during that wait -> mem_req=0 immediately, pc=RESET_PC.
REQ-040 RESET_PC=32'hFFFF_FFFC with a nop -> second fetch at address 0x0000_0000 (PC wraps).
